btn_push_encoder: RTL

Front-end input stage for the 2-bit direction stack. Synchronises and debounces four active-low direction buttons plus an active-low undo button, and converts each clean, single-button press into exactly one stack command: a one-cycle PUSH with the 2-bit direction code, or a one-cycle POP for undo. Its PUSH, POP and DATA outputs drive the stack's PUSH, POP and DATA_IN inputs directly. The stack's FULL and EMPTY flags feed back in so illegal requests are rejected here instead of being silently dropped.

---
 rtl/btn_push_encoder_if.sv | 28 ++
 rtl/btn_push_encoder.sv | 113 +++++++++++
 2 files changed

// File: rtl/btn_push_encoder_if.sv
// Stack command bus between the button encoder and the direction stack.
// master: drives PUSH/POP/DATA/REJECT, reads FULL/EMPTY; slave: the reverse.
interface btn_push_encoder_if;
    logic       PUSH;
    logic       POP;
    logic [1:0] DATA;
    logic       REJECT;
    logic       FULL;
    logic       EMPTY;

    modport master (
        output PUSH,
        output POP,
        output DATA,
        output REJECT,
        input  FULL,
        input  EMPTY
    );

    modport slave (
        input  PUSH,
        input  POP,
        input  DATA,
        input  REJECT,
        output FULL,
        output EMPTY
    );
endinterface

// File: rtl/btn_push_encoder.sv
// Synchronises and debounces four direction buttons plus undo, and turns each
// clean single press into one PUSH (with DATA code) or POP, else a REJECT.
// Ports: CLK, RST_N (async, active-low), BTN_N[3:0], UNDO_N (raw, active-low),
// stk (master: PUSH, POP, DATA, REJECT out; FULL, EMPTY in).
module btn_push_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [3:0]          BTN_N,
    input  logic                UNDO_N,
    btn_push_encoder_if.master  stk
);

    localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        WAIT_RELEASE,
        RELEASE_DB
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [4:0]  cap;
    logic [4:0]  sync1;
    logic [4:0]  s;

    logic        one_dir;
    logic        only_undo;
    logic [1:0]  dir_code;

    // Classify the captured press vector for the decision edge.
    always_comb begin
        one_dir   = !cap[4] && $onehot(cap[3:0]);
        only_undo = (cap == 5'b10000);
        dir_code  = 2'd0;
        case (cap[3:0])
            4'b0001: dir_code = 2'd0;
            4'b0010: dir_code = 2'd1;
            4'b0100: dir_code = 2'd2;
            4'b1000: dir_code = 2'd3;
            default: dir_code = 2'd0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1      <= 5'd0;
            s          <= 5'd0;
            state      <= IDLE;
            cnt        <= 16'd0;
            cap        <= 5'd0;
            stk.PUSH   <= 1'b0;
            stk.POP    <= 1'b0;
            stk.REJECT <= 1'b0;
            stk.DATA   <= 2'b00;
        end else begin
            // Inverted so a set bit means pressed.
            sync1      <= ~{UNDO_N, BTN_N};
            s          <= sync1;
            stk.PUSH   <= 1'b0;
            stk.POP    <= 1'b0;
            stk.REJECT <= 1'b0;

            case (state)
                IDLE: begin
                    if (s != 5'd0) begin
                        cap   <= s;
                        cnt   <= 16'd0;
                        state <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (s != cap) begin
                        state <= IDLE;
                    end else if (cnt == CNT_MAX) begin
                        state <= WAIT_RELEASE;
                        if (one_dir && !stk.FULL) begin
                            stk.PUSH <= 1'b1;
                            stk.DATA <= dir_code;
                        end else if (only_undo && !stk.EMPTY) begin
                            stk.POP <= 1'b1;
                        end else begin
                            stk.REJECT <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                WAIT_RELEASE: begin
                    if (s == 5'd0) begin
                        cnt   <= 16'd0;
                        state <= RELEASE_DB;
                    end
                end
                RELEASE_DB: begin
                    if (s != 5'd0) begin
                        cnt   <= 16'd0;
                        state <= WAIT_RELEASE;
                    end else if (cnt == CNT_MAX) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
